mealyol: RTL and testbench

- Overlapping Mealy-style serial sequence detector.
- Samples a 1-bit input stream once per clock. Asserts a combinational one-cycle `out` pulse during the cycle whose input bit completes the target pattern.
- Overlapping matches are detected: the tail of one match may begin the next.
- Sits on a serial bit stream as a pattern-match flag generator. No handshake.

---
 rtl/mealyol.sv | 87 ++++++++
 tb/tb_mealyol.sv | 106 ++++++++++
 2 files changed

// File: rtl/mealyol.sv
// Overlapping Mealy sequence detector. The state is the length of the pattern
// prefix matched so far; the next-state table is built from SEQ at elaboration
// using KMP failure semantics, so overlapping matches are found.
module mealyol #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1101
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int W      = $clog2(SEQ_LEN);
  localparam int NSTATE = 2 ** W;

  typedef logic [W-1:0] state_t;

  localparam state_t S0     = '0;
  localparam state_t S_LAST = state_t'(SEQ_LEN - 1);

  // Next state after k matched bits followed by bit b: the longest suffix of
  // that candidate that is also a prefix of SEQ. A full match is limited to a
  // proper suffix, which yields the longest border and therefore overlap.
  // Encodings that cannot be reached (k >= SEQ_LEN) return to S0.
  function automatic int next_fn(input int k, input logic b);
    int   l;
    int   max_len;
    int   res;
    int   j;
    logic ok;
    logic cb;
    logic pb;
    res = 0;
    if (k < SEQ_LEN) begin
      l       = k + 1;
      max_len = (l == SEQ_LEN) ? l - 1 : l;
      for (int len = max_len; len >= 1; len--) begin
        if (res == 0) begin
          ok = 1'b1;
          for (int i = 0; i < len; i++) begin
            j  = l - len + i;
            cb = (j == k) ? b : SEQ[SEQ_LEN-1-j];
            pb = SEQ[SEQ_LEN-1-i];
            if (cb != pb) ok = 1'b0;
          end
          if (ok) res = len;
        end
      end
    end
    return res;
  endfunction

  state_t nxt0_tbl [NSTATE];
  state_t nxt1_tbl [NSTATE];

  // Constant next-state table, one entry per encoding and input value.
  for (genvar k = 0; k < NSTATE; k++) begin : g_tbl
    assign nxt0_tbl[k] = state_t'(next_fn(k, 1'b0));
    assign nxt1_tbl[k] = state_t'(next_fn(k, 1'b1));
  end

  state_t state_q;
  state_t state_d;

  // State register with synchronous reset to S0.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples the pre-edge value of its inputs.
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state lookup and Mealy detect flag; reset forces the flag low.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d = state_q;
    out     = 1'b0;
    state_d = in ? nxt1_tbl[state_q] : nxt0_tbl[state_q];
    if (!rst && (state_q == S_LAST) && (in == SEQ[0])) begin
      out = 1'b1;
    end
  end

endmodule

// File: tb/tb_mealyol.sv
// Directed bench for mealyol with the default pattern 1101. Inputs change on
// the falling edge; the Mealy output is sampled shortly after, well before
// the next rising edge.
module tb_mealyol;

  logic clk;
  logic rst;
  logic din;
  logic dout;

  int checks;
  int errors;

  mealyol #(
    .SEQ_LEN (4),
    .SEQ     (4'b1101)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b", tag, got, exp);
    end
  endtask

  // One cycle with reset asserted and in=1; out must stay low.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    din = 1'b1;
    #1;
    check(tag, dout, 1'b0);
  endtask

  // One cycle with reset released and the given input bit.
  task automatic apply(input logic b, input logic exp, input string tag);
    @(negedge clk);
    rst = 1'b0;
    din = b;
    #1;
    check(tag, dout, exp);
  endtask

  // Feed n bits, first bit at index n-1, with the expected out per bit.
  task automatic run_seq(input string tag, input int n,
                         input logic [15:0] bits, input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      apply(bits[n-1-i], exp[n-1-i], $sformatf("%s_b%0d", tag, i + 1));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    din    = 1'b1;

    // Reset held two cycles with in=1, then a match proves S0 after release.
    do_reset("rst_c1");
    do_reset("rst_c2");
    run_seq("basic", 4, 16'b1101, 16'b0001);

    // Overlap through the border "1".
    do_reset("rst_ov");
    run_seq("overlap", 7, 16'b1101101, 16'b0001001);

    // Run of ones holds in S2.
    do_reset("rst_run");
    run_seq("ones", 6, 16'b111101, 16'b000001);

    // Reset while in S3 with in=1: out forced low, progress discarded.
    do_reset("rst_mid0");
    run_seq("pre", 3, 16'b110, 16'b000);
    do_reset("rst_mid_s3");
    apply(1'b1, 1'b0, "post_1");
    // From S1, "101" completes a match only if state was S1.
    run_seq("s1chk", 3, 16'b101, 16'b001);

    // Fall back to S0 after 1100, then a clean match.
    do_reset("rst_fb");
    run_seq("fallback", 8, 16'b11001100, 16'b00000000);
    run_seq("fb_then", 4, 16'b1101, 16'b0001);

    // All zeros stay in S0.
    do_reset("rst_zero");
    run_seq("zeros", 8, 16'b00000000, 16'b00000000);
    run_seq("z_then", 4, 16'b1101, 16'b0001);

    // Chain of overlapping matches.
    do_reset("rst_chain");
    run_seq("chain", 10, 16'b1101101101, 16'b0001001001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
